// File: rtl/demo_ctrl_pkg.sv
// demo_ctrl_pkg: shared definitions for the OrangeCrab run controller.
// Holds the FSM state encoding, its width and the default timing constants
// (for a 48 MHz clock) that demo_ctrl and btn_debounce use as parameter defaults.
package demo_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 480000;    // 10 ms
    localparam int unsigned DEF_LONG_PRESS_CYCLES = 48000000;  // 1 s
    localparam int unsigned DEF_POR_CYCLES        = 1024;
    localparam int unsigned DEF_RST_PULSE_CYCLES  = 64;

    typedef enum logic [STATE_W-1:0] {
        StPor       = 3'd0,
        StRun       = 3'd1,
        StPausePend = 3'd2,
        StPaused    = 3'd3,
        StStep      = 3'd4,
        StRestart   = 3'd5
    } state_e;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: button front end for demo_ctrl.
// Synchronises the raw active-low button, debounces it and classifies each
// press as short (released before LONG_PRESS_CYCLES) or long (held that long).
// Ports:
//   clk48      in   system clock
//   rst        in   synchronous active-high reset
//   btn_raw_n  in   raw asynchronous button, 0 = pressed
//   short_p    out  1-cycle pulse on the release of a short press
//   long_p     out  1-cycle pulse once a press has been held LONG_PRESS_CYCLES
module btn_debounce
    import demo_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic clk48,
    input  logic rst,
    input  logic btn_raw_n,
    output logic short_p,
    output logic long_p
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_PRESS_CYCLES);

    logic             btn_s1_q, btn_s2_q;
    logic             prs_prev_q, prs_prev_d;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic             db_prs_q, db_prs_d;
    logic             arm_q, arm_d;
    logic             held_q, held_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic             long_done_q, long_done_d;
    logic             short_q, short_d;
    logic             long_q, long_d;

    logic prs;       // synchronised sample, 1 = pressed
    logic db_rise;   // debounced level becomes pressed this cycle
    logic db_fall;   // debounced level becomes released this cycle

    assign prs     = ~btn_s2_q;
    assign short_p = short_q;
    assign long_p  = long_q;

    always_comb begin
        prs_prev_d  = prs;
        db_cnt_d    = db_cnt_q;
        db_prs_d    = db_prs_q;
        arm_d       = arm_q;
        held_d      = held_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        short_d     = 1'b0;
        long_d      = 1'b0;
        db_rise     = 1'b0;
        db_fall     = 1'b0;

        // Count only while the sample is stable and differs from the accepted level.
        if (prs == db_prs_q || prs != prs_prev_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
            db_cnt_d = '0;
            db_prs_d = prs;
            db_rise  = prs;
            db_fall  = ~prs;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        // The synchronisers come out of reset reading "pressed", so a button held
        // through reset never arms the classifier until it is really released.
        if (!db_prs_q && !prs && !prs_prev_q) begin
            arm_d = 1'b1;
        end

        if (held_q) begin
            if (db_fall) begin
                held_d      = 1'b0;
                hold_cnt_d  = '0;
                long_done_d = 1'b0;
                short_d     = ~long_done_q;
            end else begin
                if (hold_cnt_q != HoldMax) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                if (hold_cnt_q == HoldLast && !long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
            end
        end else if (db_rise && arm_q) begin
            held_d     = 1'b1;
            hold_cnt_d = '0;
        end
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            btn_s1_q    <= 1'b0;
            btn_s2_q    <= 1'b0;
            prs_prev_q  <= 1'b1;
            db_cnt_q    <= '0;
            db_prs_q    <= 1'b0;
            arm_q       <= 1'b0;
            held_q      <= 1'b0;
            hold_cnt_q  <= '0;
            long_done_q <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            btn_s1_q    <= btn_raw_n;
            btn_s2_q    <= btn_s1_q;
            prs_prev_q  <= prs_prev_d;
            db_cnt_q    <= db_cnt_d;
            db_prs_q    <= db_prs_d;
            arm_q       <= arm_d;
            held_q      <= held_d;
            hold_cnt_q  <= hold_cnt_d;
            long_done_q <= long_done_d;
            short_q     <= short_d;
            long_q      <= long_d;
        end
    end

endmodule

// File: rtl/demo_ctrl.sv
// demo_ctrl: run controller between the OrangeCrab user button and vgademo.
// Generates the demo reset (power-on and user restart) and a frame-aligned
// pause_n from short/long button presses.
// Optional macro DEMO_CTRL_FRAME_CNT_EN adds a 16-bit frame counter output.
// Ports:
//   clk48       in   48 MHz system clock
//   rst         in   synchronous active-high reset
//   btn_raw_n   in   raw asynchronous button, 0 = pressed
//   vsync       in   vgademo vsync, active-low; falling edge = frame boundary
//   pause_n     out  to vgademo pause_n, 0 = frozen
//   demo_rst_n  out  to vgademo rst_n, 0 = reset
//   state_o     out  current FSM state (debug)
//   frame_cnt   out  [15:0] frames run while unpaused (DEMO_CTRL_FRAME_CNT_EN only)
module demo_ctrl
    import demo_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int unsigned POR_CYCLES        = DEF_POR_CYCLES,
    parameter int unsigned RST_PULSE_CYCLES  = DEF_RST_PULSE_CYCLES
) (
    input  logic               clk48,
    input  logic               rst,
    input  logic               btn_raw_n,
    input  logic               vsync,
    output logic               pause_n,
    output logic               demo_rst_n,
    output logic [STATE_W-1:0] state_o
`ifdef DEMO_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int unsigned PorW = $clog2(POR_CYCLES + 1);
    localparam int unsigned RstW = $clog2(RST_PULSE_CYCLES + 1);
    localparam logic [PorW-1:0] PorLast = PorW'(POR_CYCLES - 1);
    localparam logic [RstW-1:0] RstLast = RstW'(RST_PULSE_CYCLES - 1);

    logic short_p, long_p;

    btn_debounce #(
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
    ) u_btn (
        .clk48     (clk48),
        .rst       (rst),
        .btn_raw_n (btn_raw_n),
        .short_p   (short_p),
        .long_p    (long_p)
    );

    // vsync synchroniser and falling-edge detect
    logic vs_s1_q, vs_s2_q, vs_prev_q;
    logic vs_fall;

    assign vs_fall = vs_prev_q & ~vs_s2_q;

    state_e          state_q, state_d;
    logic [PorW-1:0] por_cnt_q, por_cnt_d;
    logic [RstW-1:0] rst_cnt_q, rst_cnt_d;
    logic            pause_n_q, pause_n_d;
    logic            demo_rst_n_q, demo_rst_n_d;

    always_comb begin
        state_d   = state_q;
        por_cnt_d = por_cnt_q;
        rst_cnt_d = rst_cnt_q;

        unique case (state_q)
            StPor: begin
                if (por_cnt_q == PorLast) begin
                    state_d = StRun;
                end else begin
                    por_cnt_d = por_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (short_p) begin
                    state_d = StPausePend;
                end else if (long_p) begin
                    state_d = StRestart;
                end
            end
            StPausePend: begin
                // A cancel press beats a coincident frame boundary.
                if (short_p) begin
                    state_d = StRun;
                end else if (long_p) begin
                    state_d = StRestart;
                end else if (vs_fall) begin
                    state_d = StPaused;
                end
            end
            StPaused: begin
                if (short_p) begin
                    state_d = StRun;
                end else if (long_p) begin
                    state_d = StStep;
                end
            end
            StStep: begin
                if (short_p) begin
                    state_d = StRun;
                end else if (vs_fall) begin
                    state_d = StPaused;
                end
            end
            StRestart: begin
                if (rst_cnt_q == RstLast) begin
                    state_d = StRun;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            default: state_d = StPor;
        endcase

        // Timers restart from zero on every entry.
        if (state_d != state_q) begin
            por_cnt_d = '0;
            rst_cnt_d = '0;
        end

        pause_n_d    = (state_q != StPaused);
        demo_rst_n_d = (state_q != StPor) && (state_q != StRestart);
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            vs_s1_q      <= 1'b1;
            vs_s2_q      <= 1'b1;
            vs_prev_q    <= 1'b1;
            state_q      <= StPor;
            por_cnt_q    <= '0;
            rst_cnt_q    <= '0;
            pause_n_q    <= 1'b1;
            demo_rst_n_q <= 1'b0;
        end else begin
            vs_s1_q      <= vsync;
            vs_s2_q      <= vs_s1_q;
            vs_prev_q    <= vs_s2_q;
            state_q      <= state_d;
            por_cnt_q    <= por_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            pause_n_q    <= pause_n_d;
            demo_rst_n_q <= demo_rst_n_d;
        end
    end

    assign pause_n    = pause_n_q;
    assign demo_rst_n = demo_rst_n_q;
    assign state_o    = state_q;

`ifdef DEMO_CTRL_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_q == StPor || state_q == StRestart) begin
            frame_cnt_d = '0;
        end else if (vs_fall && pause_n_q && demo_rst_n_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
